// File: rtl/mul_pkg.sv
// mul_pkg
// Shared constants and types for the RV32M multiply sequencing controller.
// Contents:
//   F3_*       RV32M funct3 encodings handled by the sequencer
//   state_t    sequencer states (IDLE, STEP0..STEP3, DRAIN, DONE)
//   SHIFT_SEQ  lane shift select per rotation step (Gray order)
//   step_shift helper returning the shift select for a step index
package mul_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    typedef enum logic [2:0] {
        IDLE,
        STEP0,
        STEP1,
        STEP2,
        STEP3,
        DRAIN,
        DONE
    } state_t;

    localparam int SEQ_STEPS = 4;

    // Gray order keeps only one select bit toggling between steps.
    localparam logic [SEQ_STEPS-1:0][1:0] SHIFT_SEQ = {2'b10, 2'b11, 2'b01, 2'b00};

    function automatic logic [1:0] step_shift(input logic [1:0] step);
        return SHIFT_SEQ[step];
    endfunction

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// mul_seq_ctrl_if
// Core-side request/response bundle of the multiply sequencer.
//   request : valid_i, ready_o, funct3_i, op_A_i, op_B_i, flush_i
//   response: valid_o, ready_i, result_o, illegal_o
// Modports:
//   master - the core (drives the request side and ready_i)
//   slave  - the sequencer (drives ready_o and the response side)
interface mul_seq_ctrl_if #(
    parameter int XLEN = 32
);
    logic            valid_i;
    logic            ready_o;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] op_A_i;
    logic [XLEN-1:0] op_B_i;
    logic            flush_i;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] result_o;
    logic            illegal_o;

    modport master (
        output valid_i, funct3_i, op_A_i, op_B_i, flush_i, ready_i,
        input  ready_o, valid_o, result_o, illegal_o
    );

    modport slave (
        input  valid_i, funct3_i, op_A_i, op_B_i, flush_i, ready_i,
        output ready_o, valid_o, result_o, illegal_o
    );

endinterface

// File: rtl/mul_op_decode.sv
// mul_op_decode
// Decodes an RV32M funct3 into the datapath operand qualifiers.
// Ports:
//   funct3   in  RV32M funct3
//   upper    out high half of the product is requested
//   signed_a out rs1 is treated as signed
//   signed_b out rs2 is treated as signed
//   illegal  out funct3[2]=1 (divide group, not handled here)
module mul_op_decode
    import mul_pkg::*;
(
    input  logic [2:0] funct3,
    output logic       upper,
    output logic       signed_a,
    output logic       signed_b,
    output logic       illegal
);

    always_comb begin
        upper    = (funct3 != F3_MUL);
        signed_a = (funct3 == F3_MULH) || (funct3 == F3_MULHSU);
        signed_b = (funct3 == F3_MULH);
        illegal  = funct3[2];
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl
// Sequencing controller for the RV32M 4-lane 8x8 multiplier datapath.
// Accepts one multiply from the core, walks the datapath through load,
// four rotate-and-accumulate steps and a pipeline drain, then presents
// the datapath result until the core takes it.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   core                mul_seq_ctrl_if.slave request/response bundle
//   result_i            datapath result
//   upper_o, signed_A_o, signed_B_o   operand qualifiers to the datapath
//   reg_A_en_o, reg_B_en_o, mux_B_sel_o, rol_en_o, en_pipe_o, AC_en_o
//                       datapath strobes
//   shift_amount_o      lane shift select
//   ac_clr_o            one-cycle accumulator clear
// Optional feature (macro MUL_FUSE_EN): a request repeating the operands
// of the last completed multiply skips the sequence and reuses the
// accumulator contents. Only XLEN=32 is supported.
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int N_STEPS = XLEN / 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    mul_seq_ctrl_if.slave   core,
    input  logic [XLEN-1:0] result_i,
    output logic            upper_o,
    output logic            signed_A_o,
    output logic            signed_B_o,
    output logic            reg_A_en_o,
    output logic            reg_B_en_o,
    output logic            mux_B_sel_o,
    output logic            rol_en_o,
    output logic            en_pipe_o,
    output logic            AC_en_o,
    output logic [1:0]      shift_amount_o,
    output logic            ac_clr_o
);

    localparam logic [1:0] LAST_STEP = 2'(N_STEPS - 1);

    state_t     state;
    state_t     state_next;
    logic [1:0] step_idx;
    logic       accept;
    logic       fuse_hit;

    logic dec_upper;
    logic dec_signed_a;
    logic dec_signed_b;
    logic dec_illegal;

    logic upper_q;
    logic signed_a_q;
    logic signed_b_q;
    logic illegal_q;

    mul_op_decode u_decode (
        .funct3   (core.funct3_i),
        .upper    (dec_upper),
        .signed_a (dec_signed_a),
        .signed_b (dec_signed_b),
        .illegal  (dec_illegal)
    );

    // A flush in IDLE blocks acceptance, so it also drops ready.
    assign accept = (state == IDLE) && core.valid_i && !core.flush_i;

    // State register plus the qualifiers latched at accept; they are held
    // for the whole operation so the datapath sees a steady encoding.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            upper_q    <= 1'b0;
            signed_a_q <= 1'b0;
            signed_b_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                upper_q    <= dec_upper;
                signed_a_q <= dec_signed_a;
                signed_b_q <= dec_signed_b;
                illegal_q  <= dec_illegal;
            end
        end
    end

    // Rotation step index of the current STEPk state.
    always_comb begin
        step_idx = 2'd0;
        case (state)
            STEP1:   step_idx = 2'd1;
            STEP2:   step_idx = 2'd2;
            STEP3:   step_idx = 2'd3;
            default: step_idx = 2'd0;
        endcase
    end

    // Next-state and output decode. A flush outside IDLE overrides
    // everything: outputs go quiet and the FSM returns to IDLE.
    always_comb begin
        state_next     = state;
        core.ready_o   = 1'b0;
        core.valid_o   = 1'b0;
        core.result_o  = '0;
        core.illegal_o = 1'b0;
        upper_o        = 1'b0;
        signed_A_o     = 1'b0;
        signed_B_o     = 1'b0;
        reg_A_en_o     = 1'b0;
        reg_B_en_o     = 1'b0;
        mux_B_sel_o    = 1'b0;
        rol_en_o       = 1'b0;
        en_pipe_o      = 1'b0;
        AC_en_o        = 1'b0;
        shift_amount_o = 2'b00;
        ac_clr_o       = 1'b0;

        case (state)
            IDLE: begin
                core.ready_o = !core.flush_i;
                if (accept) begin
                    upper_o    = dec_upper;
                    signed_A_o = dec_signed_a;
                    signed_B_o = dec_signed_b;
                    if (dec_illegal) begin
                        state_next = DONE;
                    end else if (fuse_hit) begin
                        // Accumulator already holds this product; only the
                        // A-side qualifiers need refreshing.
                        reg_A_en_o = 1'b1;
                        state_next = DONE;
                    end else begin
                        reg_A_en_o = 1'b1;
                        reg_B_en_o = 1'b1;
                        ac_clr_o   = 1'b1;
                        state_next = STEP0;
                    end
                end
            end

            STEP0, STEP1, STEP2, STEP3: begin
                upper_o        = upper_q;
                signed_A_o     = signed_a_q;
                signed_B_o     = signed_b_q;
                en_pipe_o      = 1'b1;
                AC_en_o        = 1'b1;
                shift_amount_o = step_shift(step_idx);
                // Rotate B for the following step; the last step keeps it.
                if (step_idx != LAST_STEP) begin
                    reg_B_en_o  = 1'b1;
                    mux_B_sel_o = 1'b1;
                    rol_en_o    = 1'b1;
                end
                state_next = (state == STEP0) ? STEP1 :
                             (state == STEP1) ? STEP2 :
                             (state == STEP2) ? STEP3 : DRAIN;
            end

            DRAIN: begin
                upper_o    = upper_q;
                signed_A_o = signed_a_q;
                signed_B_o = signed_b_q;
                en_pipe_o  = 1'b1;
                state_next = DONE;
            end

            DONE: begin
                upper_o        = upper_q;
                signed_A_o     = signed_a_q;
                signed_B_o     = signed_b_q;
                core.valid_o   = 1'b1;
                core.illegal_o = illegal_q;
                core.result_o  = illegal_q ? '0 : result_i;
                if (core.ready_i) begin
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase

        if ((state != IDLE) && core.flush_i) begin
            state_next     = IDLE;
            core.valid_o   = 1'b0;
            core.result_o  = '0;
            core.illegal_o = 1'b0;
            upper_o        = 1'b0;
            signed_A_o     = 1'b0;
            signed_B_o     = 1'b0;
            reg_A_en_o     = 1'b0;
            reg_B_en_o     = 1'b0;
            mux_B_sel_o    = 1'b0;
            rol_en_o       = 1'b0;
            en_pipe_o      = 1'b0;
            AC_en_o        = 1'b0;
            shift_amount_o = 2'b00;
            ac_clr_o       = 1'b0;
        end
    end

`ifdef MUL_FUSE_EN
    logic [XLEN-1:0] last_a;
    logic [XLEN-1:0] last_b;
    logic            last_signed_a;
    logic            last_signed_b;
    logic            last_valid;

    // MUL only needs the low half, which does not depend on signedness.
    always_comb begin
        fuse_hit = last_valid
                && (core.op_A_i == last_a)
                && (core.op_B_i == last_b)
                && ((core.funct3_i == F3_MUL)
                    || ((dec_signed_a == last_signed_a)
                        && (dec_signed_b == last_signed_b)));
    end

    // Operands are captured when a full sequence starts, but only become
    // reusable once that sequence has been handed over to the core.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_valid    <= 1'b0;
            last_a        <= '0;
            last_b        <= '0;
            last_signed_a <= 1'b0;
            last_signed_b <= 1'b0;
        end else if (core.flush_i) begin
            last_valid <= 1'b0;
        end else if (accept && dec_illegal) begin
            last_valid <= 1'b0;
        end else if (accept && !fuse_hit) begin
            last_valid    <= 1'b0;
            last_a        <= core.op_A_i;
            last_b        <= core.op_B_i;
            last_signed_a <= dec_signed_a;
            last_signed_b <= dec_signed_b;
        end else if ((state == DONE) && core.ready_i && !illegal_q) begin
            last_valid <= 1'b1;
        end
    end
`else
    logic [2*XLEN-1:0] unused_ops;

    assign fuse_hit   = 1'b0;
    assign unused_ops = {core.op_A_i, core.op_B_i};
`endif

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl
// Self-checking bench for mul_seq_ctrl. A behavioural 4-lane datapath is
// attached so that results depend on the strobe sequence; expected values
// come from plain 64-bit arithmetic on the RV32M definitions.
// Honours MUL_FUSE_EN for the fused-request expectations.
module tb_mul_seq_ctrl;
    import mul_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mul_seq_ctrl_if bus ();

    logic [31:0] result_dp;
    logic        upper, signed_a, signed_b;
    logic        reg_a_en, reg_b_en, mux_b_sel, rol_en, en_pipe, ac_en, ac_clr;
    logic [1:0]  shift_amount;

    mul_seq_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .core           (bus),
        .result_i       (result_dp),
        .upper_o        (upper),
        .signed_A_o     (signed_a),
        .signed_B_o     (signed_b),
        .reg_A_en_o     (reg_a_en),
        .reg_B_en_o     (reg_b_en),
        .mux_B_sel_o    (mux_b_sel),
        .rol_en_o       (rol_en),
        .en_pipe_o      (en_pipe),
        .AC_en_o        (ac_en),
        .shift_amount_o (shift_amount),
        .ac_clr_o       (ac_clr)
    );

    int checks = 0;
    int errors = 0;

    logic [1:0] gray_ref [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    // Fusion bookkeeping of the reference model.
    bit          fz_valid = 1'b0;
    logic [31:0] fz_a = '0;
    logic [31:0] fz_b = '0;
    bit          fz_sa = 1'b0;
    bit          fz_sb = 1'b0;

    // ---------------- behavioural datapath ----------------
    logic [31:0] dp_a = '0;
    logic [31:0] dp_b = '0;
    logic        dp_sa = 1'b0;
    logic        dp_sb = 1'b0;
    logic        dp_upper = 1'b0;
    logic [63:0] dp_acc = '0;
    logic [63:0] dp_pipe = '0;

    // Four lane products for one step: lane i pairs A byte i with the byte
    // of the rotated B that currently sits in lane i.
    function automatic logic [63:0] lane_sum(input logic [31:0] a, input logic [31:0] b,
                                             input logic sa, input logic sb,
                                             input logic [1:0] shamt);
        int k;
        int m;
        longint sum;
        longint av;
        longint bv;
        logic [7:0] ab;
        logic [7:0] bb;
        case (shamt)
            2'b00:   k = 0;
            2'b01:   k = 1;
            2'b11:   k = 2;
            default: k = 3;
        endcase
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            m  = (i - k + 4) % 4;
            ab = a[8*i +: 8];
            bb = b[8*i +: 8];
            av = longint'(ab);
            bv = longint'(bb);
            if (i == 3 && sa && ab[7]) av = av - 256;
            if (m == 3 && sb && bb[7]) bv = bv - 256;
            sum = sum + ((av * bv) <<< (8 * (i + m)));
        end
        return sum;
    endfunction

    always_ff @(posedge clk) begin
        if (reg_a_en) begin
            dp_a     <= bus.op_A_i;
            dp_sa    <= signed_a;
            dp_upper <= upper;
        end
        if (reg_b_en) begin
            if (mux_b_sel && rol_en) begin
                dp_b <= {dp_b[23:0], dp_b[31:24]};
            end else if (!mux_b_sel) begin
                dp_b  <= bus.op_B_i;
                dp_sb <= signed_b;
            end
        end
        if (ac_clr) begin
            dp_acc  <= '0;
            dp_pipe <= '0;
        end else if (en_pipe) begin
            dp_acc  <= dp_acc + dp_pipe;
            dp_pipe <= ac_en ? lane_sum(dp_a, dp_b, dp_sa, dp_sb, shift_amount) : 64'd0;
        end
    end

    assign result_dp = dp_upper ? dp_acc[63:32] : dp_acc[31:0];

    // ---------------- reference and checking ----------------
    function automatic logic [31:0] expected_result(input logic [2:0] f3,
                                                    input logic [31:0] a, input logic [31:0] b);
        longint av;
        longint bv;
        logic [63:0] prod;
        if (f3[2]) return 32'h0;
        av   = (f3 == 3'b001 || f3 == 3'b010) ? longint'($signed(a)) : longint'({32'h0, a});
        bv   = (f3 == 3'b001) ? longint'($signed(b)) : longint'({32'h0, b});
        prod = 64'(av * bv);
        return (f3 == 3'b000) ? prod[31:0] : prod[63:32];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"}, 64'(bus.ready_o), 64'd1);
        checkOutput({tag, "_valid"}, 64'(bus.valid_o), 64'd0);
        checkOutput({tag, "_illegal"}, 64'(bus.illegal_o), 64'd0);
        checkOutput({tag, "_strobes"},
                    64'({reg_a_en, reg_b_en, mux_b_sel, rol_en, en_pipe, ac_en, ac_clr}), 64'd0);
        checkOutput({tag, "_shift"}, 64'(shift_amount), 64'd0);
    endtask

    task automatic applyReset();
        @(posedge clk); #1;
        rst         = 1'b1;
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.ready_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        fz_valid = 1'b0;
        checkResetValues("reset");
    endtask

    // One request from accept to handshake. bp = extra DONE cycles with
    // ready_i low; flush_at = cycle (1..) at which flush_i is raised, 0 = none.
    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input int bp, input int flush_at, input bit chk_shift);
        int          exp_lat;
        logic [31:0] exp_res;
        bit          is_ill;
        bit          fused;
        bit          seen;
        bit          sa_ref;
        bit          sb_ref;

        is_ill = f3[2];
        sa_ref = (f3 == 3'b001) || (f3 == 3'b010);
        sb_ref = (f3 == 3'b001);
        fused  = 1'b0;
`ifdef MUL_FUSE_EN
        fused = !is_ill && fz_valid && (a == fz_a) && (b == fz_b)
                && ((f3 == 3'b000) || ((sa_ref == fz_sa) && (sb_ref == fz_sb)));
`endif
        exp_lat = (is_ill || fused) ? 1 : 6;
        exp_res = expected_result(f3, a, b);

        @(posedge clk); #1;
        bus.valid_i  = 1'b1;
        bus.funct3_i = f3;
        bus.op_A_i   = a;
        bus.op_B_i   = b;
        bus.flush_i  = 1'b0;
        bus.ready_i  = 1'b0;
        #1;
        checkOutput("accept_ready", 64'(bus.ready_o), 64'd1);
        if (!is_ill) begin
            checkOutput("accept_quals", 64'({upper, signed_a, signed_b}),
                        64'({f3 != 3'b000, sa_ref, sb_ref}));
            checkOutput("accept_ac_clr", 64'(ac_clr), fused ? 64'd0 : 64'd1);
        end
        if (is_ill) begin
            fz_valid = 1'b0;
        end else if (!fused) begin
            fz_valid = 1'b0;
            fz_a     = a;
            fz_b     = b;
            fz_sa    = sa_ref;
            fz_sb    = sb_ref;
        end

        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        seen = 1'b0;
        for (int cyc = 1; cyc <= exp_lat + 2 && !seen; cyc++) begin
            if (cyc > 1) begin
                @(posedge clk); #1;
            end
            if (cyc == flush_at) begin
                bus.flush_i = 1'b1;
                bus.ready_i = 1'b1;
                #1;
                checkOutput("flush_valid", 64'(bus.valid_o), 64'd0);
                checkOutput("flush_strobes",
                            64'({reg_a_en, reg_b_en, en_pipe, ac_en, ac_clr}), 64'd0);
                @(posedge clk); #1;
                bus.flush_i = 1'b0;
                bus.ready_i = 1'b0;
                #1;
                checkOutput("flush_idle_ready", 64'(bus.ready_o), 64'd1);
                checkOutput("flush_idle_valid", 64'(bus.valid_o), 64'd0);
                fz_valid = 1'b0;
                return;
            end
            #1;
            if (chk_shift && exp_lat == 6 && cyc <= 4) begin
                checkOutput($sformatf("shift_c%0d", cyc), 64'(shift_amount), 64'(gray_ref[cyc-1]));
            end
            if (bus.valid_o) begin
                seen = 1'b1;
                checkOutput("latency", 64'(cyc), 64'(exp_lat));
                checkOutput("result", 64'(bus.result_o), 64'(exp_res));
                checkOutput("illegal", 64'(bus.illegal_o), 64'(is_ill));
                checkOutput("done_ready", 64'(bus.ready_o), 64'd0);
            end
        end

        if (!seen) begin
            checkOutput("valid_timeout", 64'd0, 64'd1);
            applyReset();
            return;
        end

        for (int k = 0; k < bp; k++) begin
            @(posedge clk); #2;
            checkOutput("bp_valid", 64'(bus.valid_o), 64'd1);
            checkOutput("bp_result", 64'(bus.result_o), 64'(exp_res));
            checkOutput("bp_ready", 64'(bus.ready_o), 64'd0);
        end

        bus.ready_i = 1'b1;
        @(posedge clk); #1;
        bus.ready_i = 1'b0;
        #1;
        checkOutput("post_hs_ready", 64'(bus.ready_o), 64'd1);
        checkOutput("post_hs_valid", 64'(bus.valid_o), 64'd0);
        if (!is_ill) fz_valid = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        int          r;

        rst          = 1'b1;
        bus.valid_i  = 1'b0;
        bus.funct3_i = 3'b000;
        bus.op_A_i   = '0;
        bus.op_B_i   = '0;
        bus.flush_i  = 1'b0;
        bus.ready_i  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("por");
        rst = 1'b0;

        applyStimulus(F3_MUL,    32'd7,        32'd6,        0, 0, 1'b1);
        applyStimulus(F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1'b1);
        applyStimulus(F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1'b1);
        applyStimulus(F3_MULHSU, 32'h80000000, 32'd2,        0, 0, 1'b1);
        applyStimulus(F3_MUL,    32'd1234,     32'd5678,     2, 0, 1'b0);
        applyStimulus(F3_MUL,    32'd9,        32'd11,       0, 3, 1'b0);
        applyStimulus(F3_MUL,    32'd3,        32'd5,        0, 0, 1'b0);
        applyStimulus(3'b100,    32'd5,        32'd6,        1, 0, 1'b0);
        applyStimulus(F3_MULHU,  32'h00010000, 32'h00010000, 0, 0, 1'b0);
        applyStimulus(F3_MUL,    32'h00010000, 32'h00010000, 0, 0, 1'b0);

        // Flush while idle must block the request.
        @(posedge clk); #1;
        bus.valid_i = 1'b1;
        bus.flush_i = 1'b1;
        #1;
        checkOutput("idle_flush_ready", 64'(bus.ready_o), 64'd0);
        checkOutput("idle_flush_ac_clr", 64'(ac_clr), 64'd0);
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
        fz_valid    = 1'b0;
        #1;
        checkOutput("idle_flush_not_taken", 64'(bus.ready_o), 64'd1);

        // Reset in the middle of a sequence.
        @(posedge clk); #1;
        bus.valid_i  = 1'b1;
        bus.funct3_i = F3_MULH;
        bus.op_A_i   = 32'h12345678;
        bus.op_B_i   = 32'h9ABCDEF0;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        fz_valid = 1'b0;
        #1;
        checkResetValues("midop_reset");

        a = 32'd0;
        b = 32'd0;
        for (int n = 0; n < 48; n++) begin
            r  = int'($urandom_range(0, 4));
            f3 = (r == 4) ? {1'b1, 2'($urandom_range(0, 3))} : 3'(r);
            if (n == 0 || $urandom_range(0, 2) != 0) begin
                a = $urandom;
                b = $urandom;
                if ($urandom_range(0, 5) == 0) a = 32'h80000000;
                if ($urandom_range(0, 5) == 0) b = 32'hFFFFFFFF;
            end
            applyStimulus(f3, a, b, int'($urandom_range(0, 3)),
                          ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 6)) : 0,
                          1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule
